// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single regfile write port between the in-order
// writeback stage and a small FIFO of multiply/divide results. The pipeline
// wins by default; a starvation counter forces a DRAIN window that stalls the
// pipeline until every buffered MDU result has retired.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_valid,
  input  logic [4:0]                    pipe_rd,
  input  logic [63:0]                   pipe_data,
  output logic                          pipe_stall,
  input  logic                          mdu_valid,
  input  logic [4:0]                    mdu_rd,
  input  logic [63:0]                   mdu_data,
  output logic                          mdu_ready,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [63:0]                   rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_e;

  // Each FIFO entry carries {rd, data}.
  logic [68:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [SW-1:0]  starve_q, starve_d;
  state_e         state_q, state_d;
  logic           rf_we_q, rf_we_d;
  logic [4:0]     rf_waddr_q, rf_waddr_d;
  logic [63:0]    rf_wdata_q, rf_wdata_d;

  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           grant_fifo;
  logic           grant_pipe;
  logic [4:0]     head_rd;
  logic [63:0]    head_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == COUNT_FULL);
  assign head_rd    = fifo_mem_q[rd_ptr_q][68:64];
  assign head_data  = fifo_mem_q[rd_ptr_q][63:0];

  // Pushes are refused while full (even if a pop is pending) and during DRAIN,
  // which is what bounds the DRAIN window to FIFO_DEPTH cycles.
  assign mdu_ready  = !reset && !fifo_full && (state_q != ST_DRAIN);
  assign push       = mdu_valid && mdu_ready;

  assign pipe_stall = (state_q == ST_DRAIN);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

  // Grant selection: DRAIN forces the FIFO head, else pipeline first, else FIFO.
  always_comb begin
    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    if (state_q == ST_DRAIN && !fifo_empty) begin
      grant_fifo = 1'b1;
    end else if (pipe_valid && state_q != ST_DRAIN) begin
      grant_pipe = 1'b1;
    end else if (!fifo_empty) begin
      grant_fifo = 1'b1;
    end
  end

  // Next-state for FIFO pointers/count, starvation counter, FSM and write port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (grant_fifo) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, grant_fifo})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Only an entry already present at the start of the cycle can starve.
    if (fifo_empty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    unique case (state_q)
      ST_NORMAL: if (starve_d == STARVE_MAX) state_d = ST_DRAIN;
      ST_DRAIN:  if (count_d == '0) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase

    // A write to x0 consumes the entry but never asserts the enable.
    if (grant_pipe) begin
      rf_we_d    = (pipe_rd != 5'd0);
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (grant_fifo) begin
      rf_we_d    = (head_rd != 5'd0);
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  // FIFO storage: written only on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {mdu_rd, mdu_data};
    end
  end

  // Control and write-port registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      state_q    <= ST_NORMAL;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 64'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed vector table, hand-written corner
// sequences and a long randomized run, all checked against a queue-based model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: MDU results as a queue of {rd,data}, plus starve/drain.
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;
  ent_t        mq[$];
  int          m_starve;
  bit          m_drain;
  bit          e_we;
  logic [4:0]  e_waddr;
  logic [63:0] e_wdata;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_starve = 0;
    m_drain  = 0;
    e_we     = 0;
    e_waddr  = 5'd0;
    e_wdata  = 64'd0;
  endfunction

  // One clock edge of the arbiter rules applied to the current inputs.
  function automatic void model_edge();
    int   pre;
    bit   acc, fifo_g, pipe_g;
    ent_t h;
    pre    = mq.size();
    acc    = mdu_valid && (pre < DEPTH) && !m_drain;
    fifo_g = 0;
    pipe_g = 0;
    if (m_drain && pre > 0)          fifo_g = 1;
    else if (pipe_valid && !m_drain) pipe_g = 1;
    else if (pre > 0)                fifo_g = 1;
    e_we = 0;
    if (pipe_g) begin
      e_we    = (pipe_rd != 5'd0);
      e_waddr = pipe_rd;
      e_wdata = pipe_data;
    end
    if (fifo_g) begin
      h       = mq.pop_front();
      e_we    = (h.rd != 5'd0);
      e_waddr = h.rd;
      e_wdata = h.data;
    end
    if (acc) mq.push_back('{rd: mdu_rd, data: mdu_data});
    if (pre == 0 || fifo_g) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (!m_drain && m_starve == LIMIT) m_drain = 1;
    else if (m_drain && mq.size() == 0) m_drain = 0;
  endfunction

  function automatic void compare_all();
    chk("rf_we", 64'(rf_we), 64'(e_we));
    if (e_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(e_waddr));
      chk("rf_wdata", rf_wdata, e_wdata);
    end
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("pipe_stall", 64'(pipe_stall), 64'(m_drain));
    chk("mdu_ready", 64'(mdu_ready), 64'((mq.size() < DEPTH) && !m_drain));
  endfunction

  task automatic step(input bit pv, input logic [4:0] prd, input logic [63:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [63:0] md);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    mdu_valid  = mv; mdu_rd  = mrd; mdu_data  = md;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    $display("cyc pv=%0b prd=%0d mv=%0b mrd=%0d -> we=%0b waddr=%0d cnt=%0d stall=%0b rdy=%0b",
             pv, prd, mv, mrd, rf_we, rf_waddr, fifo_count, pipe_stall, mdu_ready);
  endtask

  task automatic flush();
    for (int i = 0; i < DEPTH + LIMIT + 2; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          pv;
    logic [4:0]  prd;
    logic [63:0] pd;
    bit          mv;
    logic [4:0]  mrd;
    logic [63:0] md;
    bit          we;
    bit          chk_addr;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    int          cnt;
    bit          stall;
    bit          rdy;
  } vec_t;
  vec_t vt[5];

  logic [4:0]  hr;
  logic [63:0] hd;
  bit          hv;

  initial begin
    vt[0] = '{1, 5'd5, 64'h1234, 0, 5'd0, 64'h0,    1, 1, 5'd5, 64'h1234, 0, 0, 1};
    vt[1] = '{0, 5'd0, 64'h0,    1, 5'd7, 64'hDEAD, 0, 1, 5'd5, 64'h1234, 1, 0, 1};
    vt[2] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    1, 1, 5'd7, 64'hDEAD, 0, 0, 1};
    vt[3] = '{1, 5'd0, 64'h55,   1, 5'd0, 64'h66,   0, 0, 5'd0, 64'h0,    1, 0, 1};
    vt[4] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 0, 5'd0, 64'h0,    0, 0, 1};

    reset = 1'b1;
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset rf_we", 64'(rf_we), 64'd0);
    chk("reset fifo_count", 64'(fifo_count), 64'd0);
    chk("reset pipe_stall", 64'(pipe_stall), 64'd0);
    chk("reset mdu_ready", 64'(mdu_ready), 64'd0);
    chk("reset rf_waddr", 64'(rf_waddr), 64'd0);
    chk("reset rf_wdata", rf_wdata, 64'd0);
    reset = 1'b0;
    #1;
    chk("release mdu_ready", 64'(mdu_ready), 64'd1);

    // Directed vectors: pipe write, MDU into idle port, rd=0 on both sources.
    for (int i = 0; i < 5; i++) begin
      pipe_valid = vt[i].pv; pipe_rd = vt[i].prd; pipe_data = vt[i].pd;
      mdu_valid  = vt[i].mv; mdu_rd  = vt[i].mrd; mdu_data  = vt[i].md;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("vec%0d rf_we", i), 64'(rf_we), 64'(vt[i].we));
      if (vt[i].chk_addr) begin
        chk($sformatf("vec%0d rf_waddr", i), 64'(rf_waddr), 64'(vt[i].waddr));
        chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vt[i].wdata);
      end
      chk($sformatf("vec%0d fifo_count", i), 64'(fifo_count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d pipe_stall", i), 64'(pipe_stall), 64'(vt[i].stall));
      chk($sformatf("vec%0d mdu_ready", i), 64'(mdu_ready), 64'(vt[i].rdy));
      $display("vec%0d -> we=%0b waddr=%0d wdata=0x%0h cnt=%0d", i, rf_we, rf_waddr, rf_wdata, fifo_count);
    end

    // Full FIFO: third offer held off until a pop frees a slot.
    flush();
    step(1, 5'd1, 64'h11, 1, 5'd10, 64'hA0);
    step(1, 5'd2, 64'h22, 1, 5'd11, 64'hA1);
    chk("full count", 64'(fifo_count), 64'd2);
    chk("full mdu_ready", 64'(mdu_ready), 64'd0);
    step(1, 5'd3, 64'h33, 1, 5'd12, 64'hA2);
    chk("full no push", 64'(fifo_count), 64'd2);
    step(0, 5'd0, 64'h0, 1, 5'd12, 64'hA2);
    chk("full pop only", 64'(fifo_count), 64'd1);
    step(0, 5'd0, 64'h0, 1, 5'd12, 64'hA2);
    chk("push+pop count", 64'(fifo_count), 64'd1);

    // Starvation: one entry denied LIMIT cycles forces a drain.
    flush();
    step(1, 5'd3, 64'h33, 1, 5'd9, 64'hAA);
    for (int i = 0; i < LIMIT; i++) step(1, 5'(4 + i), 64'(100 + i), 0, 0, 0);
    chk("starve stall", 64'(pipe_stall), 64'd1);
    step(1, 5'd20, 64'hBEEF, 0, 0, 0);
    chk("drain waddr", 64'(rf_waddr), 64'd9);
    chk("drain wdata", rf_wdata, 64'hAA);
    chk("drain exit", 64'(pipe_stall), 64'd0);
    step(1, 5'd20, 64'hBEEF, 0, 0, 0);
    chk("held pipe waddr", 64'(rf_waddr), 64'd20);
    chk("held pipe wdata", rf_wdata, 64'hBEEF);
    step(0, 0, 0, 0, 0, 0);
    chk("no duplicate", 64'(rf_we), 64'd0);

    // Asynchronous reset in the middle of a drain with two entries buffered.
    flush();
    step(1, 5'd1, 64'h1, 1, 5'd5, 64'h50);
    step(1, 5'd2, 64'h2, 1, 5'd6, 64'h60);
    for (int i = 0; i < LIMIT - 1; i++) step(1, 5'd3, 64'(3 + i), 0, 0, 0);
    chk("pre-reset stall", 64'(pipe_stall), 64'd1);
    chk("pre-reset count", 64'(fifo_count), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("async rst stall", 64'(pipe_stall), 64'd0);
    chk("async rst rf_we", 64'(rf_we), 64'd0);
    chk("async rst count", 64'(fifo_count), 64'd0);
    chk("async rst ready", 64'(mdu_ready), 64'd0);
    pipe_valid = 0; mdu_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("post rst ready", 64'(mdu_ready), 64'd1);
    chk("post rst stall", 64'(pipe_stall), 64'd0);

    // Randomized run; pipe inputs held stable while the model says stalled.
    hv = 0; hr = 0; hd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!m_drain) begin
        hv = ($urandom_range(0, 99) < 70);
        hr = 5'($urandom);
        hd = {$urandom, $urandom};
      end
      step(hv, hr, hd, ($urandom_range(0, 99) < 45), 5'($urandom), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
